// File: rtl/fm_synth_pkg.sv
// Shared widths, FSM encoding and the quarter-wave sine table generator for fm_synth.
// The table is built from an integer Taylor series so it folds to constants at elaboration.
package fm_synth_pkg;

    localparam int PHASE_W  = 20;
    localparam int IDX_W    = 10;
    localparam int SAMPLE_W = 16;
    localparam int QTR_N    = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOD  = 2'd1,
        ST_MODW = 2'd2,
        ST_CAR  = 2'd3
    } fm_state_t;

    // Q(j) = round(32767 * sin(pi*(2j+1)/1024)), computed in Q30 fixed point.
    function automatic logic [14:0] quarter_sine(input int j);
        longint pi_q30;
        longint one_q30;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint res;
        pi_q30  = 64'sd3373259426;
        one_q30 = 64'sd1073741824;
        x       = (pi_q30 * longint'(2 * j + 1)) / 1024;
        x2      = (x * x) / one_q30;
        term    = x;
        sum     = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) / one_q30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        res = (sum * 32767 + (one_q30 / 2)) / one_q30;
        return 15'(res);
    endfunction

endpackage

// File: rtl/fm_sine_lut.sv
// Full-wave sine lookup from a quarter-wave ROM with a registered read.
// Quadrant mirroring picks the ROM address up front; the sign is applied after the read register.
module fm_sine_lut
    import fm_synth_pkg::*;
(
    input  logic                       clk,
    input  logic [IDX_W-1:0]           idx,
    output logic signed [SAMPLE_W-1:0] sample
);

    logic [14:0] rom [QTR_N];
    logic [7:0]  rom_addr;
    logic [14:0] mag_reg;
    logic        neg_reg;

    generate
        for (genvar gi = 0; gi < QTR_N; gi++) begin : g_rom
            assign rom[gi] = quarter_sine(gi);
        end
    endgenerate

    // Odd quadrants run the table backwards: 255 - j is just the bitwise complement.
    assign rom_addr = idx[8] ? ~idx[7:0] : idx[7:0];

    always_ff @(posedge clk) begin
        mag_reg <= rom[rom_addr];
        neg_reg <= idx[9];
    end

    assign sample = neg_reg ? -$signed({1'b0, mag_reg}) : $signed({1'b0, mag_reg});

endmodule

// File: rtl/fm_synth.sv
// Two-operator phase-modulation voice: one shared sine unit is time-multiplexed
// between modulator and carrier once per output sample.
module fm_synth
    import fm_synth_pkg::*;
#(
    parameter int               CLK_DIV   = 512,
    parameter logic [PHASE_W-1:0] MOD_INC = 20'h00800,
    parameter logic [PHASE_W-1:0] CAR_INC = 20'h00400,
    parameter int               MOD_SHIFT = 6,
    parameter int               ATTEN_L   = 0,
    parameter int               ATTEN_R   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic signed [SAMPLE_W-1:0] audio_l,
    output logic signed [SAMPLE_W-1:0] audio_r
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0]           div_cnt_reg;
    logic                       tick;
    fm_state_t                  state_reg;
    fm_state_t                  state_next;
    logic [PHASE_W-1:0]         mod_phase_reg;
    logic [PHASE_W-1:0]         car_phase_reg;
    logic [IDX_W-1:0]           lut_idx;
    logic [IDX_W-1:0]           car_idx;
    logic signed [SAMPLE_W-1:0] lut_out;

    assign tick = (div_cnt_reg == CNT_W'(CLK_DIV - 1));

    // Negative modulator samples wrap the carrier index modulo 1024.
    assign car_idx = car_phase_reg[PHASE_W-1 -: IDX_W] + IDX_W'(lut_out >>> MOD_SHIFT);

    fm_sine_lut u_sine (
        .clk    (clk),
        .idx    (lut_idx),
        .sample (lut_out)
    );

    always_comb begin
        state_next = state_reg;
        lut_idx    = mod_phase_reg[PHASE_W-1 -: IDX_W];
        case (state_reg)
            ST_IDLE: if (tick) state_next = ST_MOD;
            ST_MOD:  state_next = ST_MODW;
            ST_MODW: begin
                lut_idx    = car_idx;
                state_next = ST_CAR;
            end
            ST_CAR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg   <= '0;
            state_reg     <= ST_IDLE;
            mod_phase_reg <= '0;
            car_phase_reg <= '0;
            audio_l       <= '0;
            audio_r       <= '0;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + CNT_W'(1);
            state_reg   <= state_next;
            if (state_reg == ST_CAR) begin
                audio_l       <= lut_out >>> ATTEN_L;
                audio_r       <= lut_out >>> ATTEN_R;
                mod_phase_reg <= mod_phase_reg + MOD_INC;
                car_phase_reg <= car_phase_reg + CAR_INC;
            end
        end
    end

endmodule

// File: tb/tb_fm_synth.sv
// Directed bench for fm_synth: reset, sample timing/values, quarter-cycle carrier, mid-sequence reset, sine sweep.
module tb_fm_synth;

    logic               clk;
    logic               reset;
    logic signed [15:0] audio_l, audio_r;
    logic signed [15:0] audio_l2, audio_r2;
    logic [9:0]         lut_idx;
    logic signed [15:0] lut_q;

    int n_cmp;
    int n_bad;
    int edge_n;

    fm_synth dut (
        .clk     (clk),
        .reset   (reset),
        .audio_l (audio_l),
        .audio_r (audio_r)
    );

    fm_synth #(
        .CLK_DIV   (8),
        .CAR_INC   (20'h40000),
        .MOD_SHIFT (15)
    ) dut_qtr (
        .clk     (clk),
        .reset   (reset),
        .audio_l (audio_l2),
        .audio_r (audio_r2)
    );

    fm_sine_lut u_lut (
        .clk    (clk),
        .idx    (lut_idx),
        .sample (lut_q)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance to just after the given rising edge, counted from reset release.
    task automatic step_to(input int target);
        while (edge_n < target) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic check_pair(input string tag, input int exp_l, input int exp_r);
        check_val({tag, "_l"}, audio_l, exp_l);
        check_val({tag, "_r"}, audio_r, exp_r);
    endtask

    task automatic check_qtr(input string tag, input int exp_l, input int exp_r);
        check_val({tag, "_l"}, audio_l2, exp_l);
        check_val({tag, "_r"}, audio_r2, exp_r);
    endtask

    int lut_addr [7] = '{0, 255, 256, 512, 767, 1023, 1};
    int lut_exp  [7] = '{101, 32767, 32767, -101, -32767, -101, 302};

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        edge_n  = 0;
        lut_idx = '0;
        reset   = 1'b1;

        // Reset held 200 ns (5 clocks at 25 MHz)
        #101;
        check_pair("rst_hold", 0, 0);
        #98;
        check_pair("rst_end", 0, 0);
        #1;
        reset  = 1'b0;           // t = 200, falling edge
        edge_n = 0;

        // Quarter-cycle carrier instance (CLK_DIV = 8): updates at edges 11,19,27,35,43
        step_to(10);  check_qtr("qtr_pre", 0, 0);
        step_to(11);  check_qtr("qtr_s1", 101, 50);
        step_to(18);  check_qtr("qtr_hold", 101, 50);
        step_to(19);  check_qtr("qtr_s2", 32767, 16383);
        step_to(27);  check_qtr("qtr_s3", -101, -51);
        step_to(35);  check_qtr("qtr_s4", -32767, -16384);
        step_to(43);  check_qtr("qtr_wrap", 101, 50);

        // Default voice: first update 4 edges after count reaches 511
        step_to(514);  check_pair("s1_pre", 0, 0);
        step_to(515);  check_pair("s1", 302, 151);
        step_to(1026); check_pair("s1_hold", 302, 151);
        step_to(1027); check_pair("s2", 1708, 854);

        // Third sequence: tick edge 1536, MODW after edge 1537
        step_to(1537);
        #5;
        reset = 1'b1;
        #1;
        check_pair("mid_rst", 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_pair("mid_rst_hold", 0, 0);
        reset  = 1'b0;
        edge_n = 0;
        step_to(514);  check_pair("rel_pre", 0, 0);
        step_to(515);  check_pair("rel_s1", 302, 151);

        // Standalone sine sweep: value appears one clock after its address
        for (int i = 0; i < 7; i++) begin
            lut_idx = 10'(lut_addr[i]);
            #1;
            if (i > 0) check_val($sformatf("lut_hold_%0d", lut_addr[i]), lut_q, lut_exp[i-1]);
            @(posedge clk);
            #1;
            check_val($sformatf("lut_%0d", lut_addr[i]), lut_q, lut_exp[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
